a_drain: RTL and testbench

A_DRAIN -- requirements
Module: a_drain

---
 rtl/a_drain.sv | 108 ++++++++++
 tb/tb_a_drain.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a_drain.sv
// Pipeline sink: buffers valid/stall words in a small FIFO and delivers them
// one at a time over a four-phase req/ack handshake, counting acked words.
module a_drain #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic               stall_o,
  output logic               req_o,
  output logic [WIDTH-1:0]   data_o,
  input  logic               ack_i,
  output logic [COUNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_e;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  // Extra pointer bit separates full (MSBs differ) from empty (all bits equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = v_i && !full;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    count_d  = count_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          data_d  = mem_q[rd_ptr_q[AW-1:0]];
          pop     = 1'b1;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_i) begin
          req_d   = 1'b0;
          count_d = count_q + COUNT_W'(1);
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (!ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      data_q   <= data_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers already makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign stall_o = full;
  assign req_o   = req_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_a_drain.sv
// Self-checking bench for a_drain: directed scenarios plus a random phase,
// all scored against a queue-based model of the buffered words.
module tb_a_drain;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               v_i = 1'b0;
  logic [WIDTH-1:0]   data_i = '0;
  logic               stall_o;
  logic               req_o;
  logic [WIDTH-1:0]   data_o;
  logic               ack_i = 1'b0;
  logic [COUNT_W-1:0] count_o;

  a_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .v_i     (v_i),
    .data_i  (data_i),
    .stall_o (stall_o),
    .req_o   (req_o),
    .data_o  (data_o),
    .ack_i   (ack_i),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: words waiting in the FIFO, word in the output register, deliveries.
  logic [WIDTH-1:0] fifo_m [$];
  logic [WIDTH-1:0] last_data;
  logic [WIDTH-1:0] dlog [$];
  int               cseq [$];
  int               cnt_m;
  int               acc_cnt;
  bit               auto_ack;
  bit               auto_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the random agents, record what the edge should do,
  // then score the outputs 1 time unit after the edge.
  task automatic tick();
    bit               acc;
    logic             prev_req;
    logic [WIDTH-1:0] d;
    if (auto_ack) begin
      if (req_o && !ack_i && ($urandom_range(0, 1) == 1)) ack_i = 1'b1;
      else if (!req_o && ack_i && ($urandom_range(0, 1) == 1)) ack_i = 1'b0;
    end
    if (auto_v && !(v_i && stall_o)) begin
      v_i    = ($urandom_range(0, 2) != 0);
      data_i = $urandom;
    end
    acc      = rst && v_i && !stall_o;
    d        = data_i;
    prev_req = req_o;
    @(posedge clk);
    #1;
    if (!rst) begin
      fifo_m.delete();
      dlog.delete();
      cseq.delete();
      last_data = '0;
      cnt_m     = 0;
      acc_cnt   = 0;
      check("rst_req", req_o, 0);
      check("rst_data", data_o, 0);
      check("rst_count", count_o, 0);
      check("rst_stall", stall_o, 0);
    end else begin
      if (req_o && !prev_req) begin
        check("load_from_nonempty", (fifo_m.size() != 0), 1);
        if (fifo_m.size() != 0) last_data = fifo_m.pop_front();
      end
      if (!req_o && prev_req) begin
        cnt_m++;
        dlog.push_back(last_data);
        cseq.push_back(int'(count_o));
      end
      if (acc) begin
        fifo_m.push_back(d);
        acc_cnt++;
      end
      check("data_o", data_o, last_data);
      check("count_o", count_o, 64'(cnt_m % (1 << COUNT_W)));
      check("stall_o", stall_o, (fifo_m.size() == DEPTH));
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    ack_i    = 1'b0;
    auto_ack = 1'b0;
    auto_v   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w, input int budget);
    bit ok = 1'b0;
    bit a;
    v_i    = 1'b1;
    data_i = w;
    for (int i = 0; i < budget && !ok; i++) begin
      a = !stall_o;
      tick();
      ok = a;
    end
    v_i = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    v_i      = 1'b0;
    auto_v   = 1'b0;
    auto_ack = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (fifo_m.size() == 0) && !req_o && !ack_i;
    end
    auto_ack = 1'b0;
    check("drain_done", done, 1);
  endtask

  initial begin
    last_data = '0;
    cnt_m     = 0;
    acc_cnt   = 0;
    auto_ack  = 1'b0;
    auto_v    = 1'b0;

    // Reset with v_i asserted: nothing may be captured.
    v_i    = 1'b1;
    data_i = 32'h1234_5678;
    do_reset();
    v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_req_idle", req_o, 0);
    end

    // Single word: req_o after two edges, ack one cycle after req, release.
    v_i    = 1'b1;
    data_i = 32'hDEAD_BEEF;
    tick();
    v_i = 1'b0;
    check("lat_edge1_req", req_o, 0);
    tick();
    check("lat_edge2_req", req_o, 1);
    check("lat_edge2_data", data_o, 32'hDEAD_BEEF);
    tick();
    check("req_held", req_o, 1);
    ack_i = 1'b1;
    tick();
    check("ack_req_low", req_o, 0);
    check("ack_count", count_o, 1);
    tick();
    ack_i = 1'b0;
    tick();
    tick();
    check("single_count", count_o, 1);
    check("single_idle", req_o, 0);

    // Back-pressure: ack held low, words 1..7 offered.
    do_reset();
    for (int w = 1; w <= 5; w++) push_word(w, 4);
    v_i    = 1'b1;
    data_i = 6;
    for (int i = 0; i < 3; i++) tick();
    check("bp_stall", stall_o, 1);
    check("bp_data", data_o, 1);
    check("bp_req", req_o, 1);
    check("bp_fifo_words", fifo_m.size(), DEPTH);
    auto_ack = 1'b1;
    push_word(6, 60);
    push_word(7, 60);
    drain(100);
    check("bp_delivered", dlog.size(), 7);
    for (int k = 0; k < dlog.size() && k < 7; k++) check("bp_order", dlog[k], k + 1);
    check("bp_count", count_o, 7);

    // Full FIFO and pop in the same cycle: the offered word waits one edge.
    do_reset();
    for (int w = 1; w <= 5; w++) push_word(w, 4);
    v_i    = 1'b1;
    data_i = 6;
    ack_i  = 1'b1;
    tick();
    ack_i = 1'b0;
    tick();
    check("pop_cycle_stall", stall_o, 1);
    tick();
    check("pop_cycle_req", req_o, 1);
    check("pop_cycle_data", data_o, 2);
    check("pop_cycle_not_taken", acc_cnt, 5);
    check("pop_cycle_stall_drop", stall_o, 0);
    tick();
    check("pop_cycle_taken", acc_cnt, 6);
    v_i = 1'b0;
    drain(100);
    check("pop_delivered", dlog.size(), 6);
    for (int k = 0; k < dlog.size() && k < 6; k++) check("pop_order", dlog[k], k + 1);

    // Reset in the middle of a transfer with three words queued.
    do_reset();
    for (int w = 1; w <= 4; w++) push_word(32'hA0 + w, 4);
    check("mid_req_before", req_o, 1);
    check("mid_queued", fifo_m.size(), 3);
    rst = 1'b0;
    tick();
    rst      = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_nothing_delivered", req_o, 0);
    end
    auto_ack = 1'b0;
    ack_i    = 1'b0;

    // Random traffic against the scoreboard.
    do_reset();
    auto_v   = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 3000; i++) tick();
    drain(200);
    check("rand_all_delivered", dlog.size(), acc_cnt);

    // Counter wrap: 17 deliveries with a 4-bit counter.
    do_reset();
    auto_ack = 1'b1;
    for (int w = 0; w < 17; w++) push_word($urandom, 60);
    drain(200);
    check("wrap_deliveries", cseq.size(), 17);
    for (int k = 0; k < cseq.size() && k < 17; k++) check("wrap_seq", cseq[k], (k + 1) % 16);
    check("wrap_final", count_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
